// File: rtl/chip_result_rx_pkg.sv
// ============================================================================
// chip_result_rx_pkg : shared widths, defaults and FSM encoding for the AES result receiver
// Rev 1.0
// ============================================================================
`default_nettype none

package chip_result_rx_pkg;

  localparam int AES_BLOCK_W        = 128;
  localparam int AES_BYTES          = 16;
  localparam int AES_RX_TIMEOUT_DEF = 1000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/chip_result_rx_if.sv
// ============================================================================
// chip_result_rx_if : chip-side byte port plus assembled-block result bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface chip_result_rx_if
  import chip_result_rx_pkg::*;
#(
  parameter int BYTES = AES_BYTES
) ();

  logic                       shakehand;
  logic [7:0]                 rx;
  logic [8*BYTES-1:0]         data;
  logic                       en;
  logic [$clog2(BYTES)-1:0]   byte_idx;
  logic                       drop;
  logic [15:0]                drop_cnt;

  modport master (
    output shakehand, rx,
    input  data, en, byte_idx, drop, drop_cnt
  );

  modport slave (
    input  shakehand, rx,
    output data, en, byte_idx, drop, drop_cnt
  );

endinterface

`default_nettype wire

// File: rtl/chip_result_rx_toggle_sync.sv
// ============================================================================
// toggle_sync : multi-flop synchroniser for a bus plus its toggle strobe, emits a tog pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module toggle_sync #(
  parameter int STAGES = 2,
  parameter int W      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         strobe,
  input  logic [W-1:0] bus,
  output logic [W-1:0] bus_sync,
  output logic         tog
);

  // Strobe travels in the MSB alongside the bus so both see identical latency.
  logic [STAGES-1:0][W:0] pipe;
  logic                   sh_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe    <= '0;
      sh_prev <= 1'b0;
    end else begin
      pipe    <= {pipe[STAGES-2:0], {strobe, bus}};
      sh_prev <= pipe[STAGES-1][W];
    end
  end

  assign bus_sync = pipe[STAGES-1][W-1:0];
  assign tog      = pipe[STAGES-1][W] ^ sh_prev;

endmodule

`default_nettype wire

// File: rtl/chip_result_rx.sv
// ============================================================================
// chip_result_rx : assembles toggle-strobed result bytes into blocks, drops stalled frames
// Rev 1.0
// ============================================================================
`default_nettype none

module chip_result_rx
  import chip_result_rx_pkg::*;
#(
  parameter int BYTES       = AES_BYTES,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = AES_RX_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  chip_result_rx_if.slave bus
);

  localparam int                DATA_W   = 8 * BYTES;
  localparam int                IDX_W    = $clog2(BYTES);
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT - 1);

  logic [7:0]        byte_sync;
  logic              tog;

  rx_state_e         state, state_nxt;
  logic [DATA_W-1:0] asm_reg, asm_nxt, shifted;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [CNT_W-1:0]  tcnt, tcnt_nxt;
  logic              done, done_nxt;
  logic              drop_nxt;
  logic              en_q, drop_q;
  logic [DATA_W-1:0] data_q;
  logic [15:0]       drop_count;

  toggle_sync #(
    .STAGES (SYNC_STAGES),
    .W      (8)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .strobe   (bus.shakehand),
    .bus      (bus.rx),
    .bus_sync (byte_sync),
    .tog      (tog)
  );

  assign shifted = {asm_reg[DATA_W-9:0], byte_sync};

  always_comb begin
    state_nxt = state;
    asm_nxt   = asm_reg;
    idx_nxt   = idx;
    tcnt_nxt  = '0;
    done_nxt  = 1'b0;
    drop_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (tog) begin
          asm_nxt   = shifted;
          idx_nxt   = IDX_W'(1);
          state_nxt = RECV;
        end
      end
      RECV: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (tog) begin
          asm_nxt = shifted;
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else if (tcnt == CNT_MAX) begin
          drop_nxt  = 1'b1;
          asm_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      asm_reg    <= '0;
      idx        <= '0;
      tcnt       <= '0;
      done       <= 1'b0;
      en_q       <= 1'b0;
      drop_q     <= 1'b0;
      data_q     <= '0;
      drop_count <= '0;
    end else begin
      state   <= state_nxt;
      asm_reg <= asm_nxt;
      idx     <= idx_nxt;
      tcnt    <= tcnt_nxt;
      done    <= done_nxt;
      en_q    <= done;
      drop_q  <= drop_nxt;
      if (done) begin
        data_q <= asm_reg;
      end
      if (drop_nxt && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  assign bus.data     = data_q;
  assign bus.en       = en_q;
  assign bus.byte_idx = idx;
  assign bus.drop     = drop_q;
  assign bus.drop_cnt = drop_count;

endmodule

`default_nettype wire

// File: tb/tb_chip_result_rx.sv
// ============================================================================
// tb_chip_result_rx : randomized self-checking bench with a cycle-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_chip_result_rx;
  import chip_result_rx_pkg::*;

  localparam int S   = 2;
  localparam int TMO = AES_RX_TIMEOUT_DEF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chip_result_rx_if #(.BYTES(AES_BYTES)) bus ();

  chip_result_rx #(
    .BYTES       (AES_BYTES),
    .SYNC_STAGES (S),
    .TIMEOUT     (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each toggle is scheduled to land on a known clock edge; bytes
  // accumulate in a queue and the frame rules are applied directly to that queue.
  typedef struct {
    int unsigned at_edge;
    logic [7:0]  b;
  } tog_t;

  tog_t         tq[$];
  logic [7:0]   m_bytes[$];
  int unsigned  cyc = 0;
  int unsigned  last_acc = 0;
  bit           pend_en = 1'b0;
  logic [127:0] pend_data = '0;
  logic [127:0] m_data = '0;
  bit           m_en = 1'b0;
  bit           m_drop = 1'b0;
  int           m_drops = 0;
  int           m_en_total = 0;
  int           en_seen = 0;
  bit           preset_active = 1'b0;
  int           drops_at_preset = 0;

  function automatic logic [15:0] exp_drop_cnt();
    int v;
    v = preset_active ? (16'hFFFE + (m_drops - drops_at_preset)) : m_drops;
    return (v > 16'hFFFF) ? 16'hFFFF : 16'(v);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      tq.delete();
      m_bytes.delete();
      pend_en = 1'b0;
      m_en    = 1'b0;
      m_drop  = 1'b0;
      m_data  = '0;
      m_drops = 0;
    end else begin
      m_en   = 1'b0;
      m_drop = 1'b0;
      if (pend_en) begin
        m_en    = 1'b1;
        m_data  = pend_data;
        pend_en = 1'b0;
        m_en_total++;
      end
      if (tq.size() > 0 && tq[0].at_edge == cyc) begin
        m_bytes.push_back(tq[0].b);
        void'(tq.pop_front());
        last_acc = cyc;
        if (m_bytes.size() == AES_BYTES) begin
          for (int i = 0; i < AES_BYTES; i++) pend_data[127-8*i -: 8] = m_bytes[i];
          pend_en = 1'b1;
          m_bytes.delete();
        end
      end else if (m_bytes.size() > 0 && (cyc - last_acc) == TMO) begin
        m_drop = 1'b1;
        m_drops++;
        m_bytes.delete();
      end
    end
    #1;
    if (bus.en === 1'b1) en_seen++;
    check("en",       bus.en,       m_en);
    check("drop",     bus.drop,     m_drop);
    check("byte_idx", bus.byte_idx, m_bytes.size());
    check("drop_cnt", bus.drop_cnt, exp_drop_cnt());
    check("data",     bus.data,     m_data);
  end

  // rx settles 4 cycles before the strobe edge; spacing is toggle-to-toggle distance.
  task automatic send(input logic [7:0] b, input int spacing);
    tog_t t;
    bus.rx = b;
    repeat (4) @(negedge clk);
    bus.shakehand = ~bus.shakehand;
    t.at_edge = cyc + S + 1;
    t.b       = b;
    tq.push_back(t);
    repeat (spacing - 4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] base, input bit rnd);
    for (int i = 0; i < AES_BYTES; i++)
      send(rnd ? 8'($urandom) : base + 8'(i), rnd ? int'($urandom_range(8, 14)) : 8);
  endtask

  logic [127:0] blk_b;
  int           en_before;

  initial begin
    bus.shakehand = 1'b0;
    bus.rx        = 8'h00;
    rst_n         = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_data", bus.data, 128'h0);
    check("reset_idx",  bus.byte_idx, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame with incrementing bytes
    send_frame(8'h00, 1'b0);
    repeat (10) @(negedge clk);
    check("t1_data", bus.data, 128'h000102030405060708090A0B0C0D0E0F);
    check("t1_en_count", en_seen, 1);

    // Back-to-back frames
    send_frame(8'hA0, 1'b0);
    send_frame(8'hB0, 1'b0);
    repeat (10) @(negedge clk);
    blk_b = 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;
    check("t2_data", bus.data, blk_b);
    check("t2_en_count", en_seen, 3);
    check("t2_idx", bus.byte_idx, 4'd0);

    // Partial frame stalls and is dropped
    for (int i = 0; i < 5; i++) send(8'h50 + 8'(i), (i == 4) ? TMO + 10 : 8);
    check("t3_drop_cnt", bus.drop_cnt, 16'd1);
    check("t3_data_kept", bus.data, blk_b);
    send_frame(8'h60, 1'b0);
    repeat (10) @(negedge clk);
    check("t3_data", bus.data, 128'h606162636465666768696A6B6C6D6E6F);

    // Toggle on the exact expiry cycle is accepted; one cycle later is a drop
    send(8'h70, 8);
    send(8'h71, 8);
    send(8'h72, TMO);
    send(8'h73, 8);
    check("t4_no_drop", bus.drop_cnt, 16'd1);
    check("t4_idx", bus.byte_idx, 4'd4);
    send(8'h74, TMO + 1);
    send(8'h80, 8);
    check("t4_late_drop", bus.drop_cnt, 16'd2);
    check("t4_idx_restart", bus.byte_idx, 4'd1);
    for (int i = 1; i < AES_BYTES; i++) send(8'h80 + 8'(i), 8);
    repeat (10) @(negedge clk);
    check("t4_data", bus.data, 128'h808182838485868788898A8B8C8D8E8F);

    // Random frames, some with a mid-frame stall
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < 3; i++) send(8'($urandom), (i == 2) ? TMO + 5 : 9);
      end
      send_frame(8'h00, 1'b1);
    end
    repeat (10) @(negedge clk);
    check("rand_en_total", en_seen, m_en_total);

    // Reset mid-frame
    for (int i = 0; i < 9; i++) send(8'h90 + 8'(i), 8);
    rst_n         = 1'b0;
    bus.shakehand = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_rst_data", bus.data, 128'h0);
    check("t5_rst_en",   bus.en, 1'b0);
    check("t5_rst_idx",  bus.byte_idx, 4'd0);
    check("t5_rst_dcnt", bus.drop_cnt, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    en_before = en_seen;
    send_frame(8'hC0, 1'b0);
    repeat (10) @(negedge clk);
    check("t5_en_once", en_seen - en_before, 1);
    check("t5_data", bus.data, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
    check("t5_dcnt", bus.drop_cnt, 16'd0);

    // Saturation of the drop counter
    force dut.drop_count = 16'hFFFE;
    drops_at_preset = m_drops;
    preset_active   = 1'b1;
    #1;
    release dut.drop_count;
    @(negedge clk);
    for (int k = 0; k < 3; k++) send(8'hE0 + 8'(k), TMO + 10);
    check("t6_sat", bus.drop_cnt, 16'hFFFF);
    check("t6_data_kept", bus.data, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
